// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: datapath widths,
// reset PC default and the legacy FSM state encoding.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    // Fetch FSM state encoding
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] DONE  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

endpackage

// File: rtl/instruction_fetch_unit_ifid.sv
// Single-entry IF/ID buffer with valid/ready handshake.
// Priority: reset, flush, load, drain (ready), otherwise hold.
module ifid_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic            ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    // Buffer register: load a new entry, flush it, or let the consumer drain it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// feeds the IF/ID buffer. Handles redirect, backpressure, misaligned
// redirect faults and end-of-program stop.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     IMEM_BYTES = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] Inst_Address,
    input  logic [ILEN-1:0] Instruction,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);

    logic [XLEN-1:0] pc, pc_next;
    logic [1:0]      state, state_next;
    logic [XLEN-1:0] fault_addr_next;
    logic            accept, in_range, misaligned;
    logic            buf_load, buf_flush;

    assign Inst_Address = pc;
    assign done         = (state == DONE);
    assign fault        = (state == FAULT);
    assign accept       = !out_valid || out_ready;
    assign in_range     = (pc + 64'd4) <= IMEM_LIMIT;
    assign misaligned   = (redirect_target[1:0] != 2'b00);

    // Next-state, next-PC and buffer control decisions
    always_comb begin
        pc_next         = pc;
        state_next      = state;
        fault_addr_next = fault_addr;
        buf_load        = 1'b0;
        buf_flush       = 1'b0;
        case (state)
            FETCH: begin
                if (redirect && misaligned) begin
                    state_next      = FAULT;
                    fault_addr_next = redirect_target;
                    buf_flush       = 1'b1;
                end else if (redirect) begin
                    pc_next   = redirect_target;
                    buf_flush = 1'b1;
                end else if (!in_range) begin
                    state_next = DONE;
                end else if (accept) begin
                    buf_load = 1'b1;
                    pc_next  = pc + 64'd4;
                end
            end
            DONE: begin
                // An aligned redirect restarts fetch; any stale buffered
                // entry is older-path work, so it is flushed as in FETCH.
                if (redirect && misaligned) begin
                    state_next      = FAULT;
                    fault_addr_next = redirect_target;
                    buf_flush       = 1'b1;
                end else if (redirect) begin
                    pc_next    = redirect_target;
                    state_next = FETCH;
                    buf_flush  = 1'b1;
                end
            end
            default: begin
                // FAULT (and the unused encoding) park until reset
                state_next = FAULT;
                buf_flush  = 1'b1;
            end
        endcase
    end

    // PC, FSM state and fault address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            fault_addr <= '0;
        end else begin
            pc         <= pc_next;
            state      <= state_next;
            fault_addr <= fault_addr_next;
        end
    end

    ifid_buffer u_ifid (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .flush    (buf_flush),
        .ready    (out_ready),
        .in_instr (Instruction),
        .in_pc    (pc),
        .valid    (out_valid),
        .instr    (out_instr),
        .pc       (out_pc)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: byte-addressed memory model, a
// behavioural reference checked every cycle, and directed scenarios
// with literal expectations.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        redirect;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        done;
    logic        fault;
    logic [63:0] fault_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] words [4] = '{32'h02853483, 32'h009A84B3, 32'h00148493, 32'h02953423};
    logic [7:0]  mem [16];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(64'd0), .IMEM_BYTES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .Inst_Address    (Inst_Address),
        .Instruction     (Instruction),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .done            (done),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    initial begin
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                mem[w*4+b] = words[w][b*8 +: 8];
    end

    function automatic logic [31:0] word_at(input logic [63:0] a);
        int unsigned i;
        if (a > 64'd12) return 32'h0;
        i = int'(a[3:0]);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    // Instruction memory: combinational little-endian read
    always_comb Instruction = word_at(Inst_Address);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference
    logic        m_known = 1'b0;
    logic [63:0] m_pc, m_opc, m_faddr;
    logic [31:0] m_instr;
    logic        m_valid, m_done, m_fault;

    always @(posedge clk) begin
        if (reset) begin
            m_known <= 1'b1;
            m_pc <= 64'd0; m_valid <= 1'b0; m_instr <= '0; m_opc <= '0;
            m_done <= 1'b0; m_fault <= 1'b0; m_faddr <= '0;
        end else if (m_fault) begin
            m_valid <= 1'b0;
        end else if (redirect && redirect_target[1:0] != 2'b00) begin
            m_fault <= 1'b1; m_done <= 1'b0; m_faddr <= redirect_target; m_valid <= 1'b0;
        end else if (redirect) begin
            m_pc <= redirect_target; m_done <= 1'b0; m_valid <= 1'b0;
        end else if (m_pc + 64'd4 > 64'd16) begin
            m_done <= 1'b1;
            if (out_ready) m_valid <= 1'b0;
        end else if (!m_valid || out_ready) begin
            m_valid <= 1'b1; m_instr <= word_at(m_pc); m_opc <= m_pc; m_pc <= m_pc + 64'd4;
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        if (m_known) begin
            chk("cyc_addr",  Inst_Address, m_pc);
            chk("cyc_valid", 64'(out_valid), 64'(m_valid));
            chk("cyc_done",  64'(done), 64'(m_done));
            chk("cyc_fault", 64'(fault), 64'(m_fault));
            chk("cyc_faddr", fault_addr, m_faddr);
            if (m_valid) begin
                chk("cyc_opc",   out_pc, m_opc);
                chk("cyc_instr", 64'(out_instr), 64'(m_instr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_target = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_addr",  Inst_Address, 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_faddr", fault_addr, 64'd0);
        chk("rst_opc",   out_pc, 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);

        // Streaming fetch of the whole program
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_pc",    out_pc, 64'(4*i));
            chk("t1_instr", 64'(out_instr), 64'(words[i]));
            chk("t1_valid", 64'(out_valid), 64'd1);
        end
        tick();
        chk("t1_done",     64'(done), 64'd1);
        chk("t1_drained",  64'(out_valid), 64'd0);

        // Backpressure
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick();
        chk("t2_pc", out_pc, 64'd4);
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("t2_hold_pc",    out_pc, 64'd4);
            chk("t2_hold_instr", 64'(out_instr), 64'h009A84B3);
            chk("t2_hold_addr",  Inst_Address, 64'd8);
        end
        out_ready = 1'b1;
        tick();
        chk("t2_release_pc", out_pc, 64'd8);

        // Redirect flush
        redirect = 1'b1; redirect_target = 64'd0;
        tick();
        chk("t3_valid", 64'(out_valid), 64'd0);
        chk("t3_addr",  Inst_Address, 64'd0);
        redirect = 1'b0;
        tick();
        chk("t3_pc",    out_pc, 64'd0);
        chk("t3_instr", 64'(out_instr), 64'h02853483);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t3_stream_pc", out_pc, 64'(4*i));
        end
        tick();
        chk("t3_done", 64'(done), 64'd1);

        // Restart from DONE
        redirect = 1'b1; redirect_target = 64'd8;
        tick();
        chk("t4_done_clr", 64'(done), 64'd0);
        redirect = 1'b0;
        tick();
        chk("t4_pc8",  out_pc, 64'd8);
        tick();
        chk("t4_pc12", out_pc, 64'd12);
        tick();
        chk("t4_done", 64'(done), 64'd1);

        // Misaligned redirect fault
        redirect = 1'b1; redirect_target = 64'd6;
        tick();
        chk("t5_fault", 64'(fault), 64'd1);
        chk("t5_faddr", fault_addr, 64'd6);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_addr",  Inst_Address, 64'd16);
        redirect_target = 64'd0;
        tick();
        chk("t5_sticky",      64'(fault), 64'd1);
        chk("t5_ignore_addr", Inst_Address, 64'd16);
        chk("t5_keep_faddr",  fault_addr, 64'd6);
        redirect = 1'b0; reset = 1'b1;
        tick();
        chk("t5_rst_fault", 64'(fault), 64'd0);
        chk("t5_rst_addr",  Inst_Address, 64'd0);
        reset = 1'b0;
        tick();
        chk("t5_restart_pc", out_pc, 64'd0);

        // Reset during a stall
        out_ready = 1'b0;
        tick();
        chk("t6_stall_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_addr",  Inst_Address, 64'd0);
        chk("t6_done",  64'(done), 64'd0);
        chk("t6_fault", 64'(fault), 64'd0);

        // Misaligned redirect with a valid buffer in FETCH
        reset = 1'b0; out_ready = 1'b1;
        tick(); tick();
        redirect = 1'b1; redirect_target = 64'h2;
        tick();
        chk("t7_fault", 64'(fault), 64'd1);
        chk("t7_valid", 64'(out_valid), 64'd0);
        chk("t7_faddr", fault_addr, 64'h2);
        redirect = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the byte-addressed instruction memory.
- Owns the 64-bit program counter and drives Inst_Address to the memory. The memory returns the 32-bit little-endian Instruction combinationally.
- Registers Instruction and PC into a single-entry IF/ID buffer, which the decoder consumes through a valid/ready handshake.
- Handles branch redirect, backpressure, misaligned-target faults and end-of-program stop.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- IMEM_BYTES, 16, instruction memory size in bytes. Fetch is legal only while PC+4 <= IMEM_BYTES.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- Inst_Address  output  64  byte address to the instruction memory; equals the PC register.
- Instruction  input  32  word returned by the instruction memory for Inst_Address, same cycle.
- redirect  input  1  taken branch/jump this cycle.
- redirect_target  input  64  new PC when redirect=1.
- out_valid  output  1  IF/ID buffer holds a valid instruction.
- out_ready  input  1  decoder accepts the buffer this cycle.
- out_instr  output  32  buffered instruction.
- out_pc  output  64  PC of out_instr.
- done  output  1  PC has left the memory range; fetch stopped.
- fault  output  1  sticky misaligned-redirect fault.
- fault_addr  output  64  offending redirect_target.

Behaviour:
- Reset (synchronous, at a rising edge with reset=1):
  - PC=RESET_PC, state=FETCH, out_valid=0, out_instr=0, out_pc=0, done=0, fault=0, fault_addr=0.
  - Reset has priority over every other input, including mid-stall and in FAULT.
- States:
  - FETCH: normal operation.
  - DONE: PC is out of range.
  - FAULT: terminal until reset.
- Derived signals:
  - accept = !out_valid || out_ready.
  - in_range = (PC + 4 <= IMEM_BYTES), computed in 64 bits; no wrap is possible for realistic sizes.
- FETCH, per edge, in priority order:
  1. redirect=1 with redirect_target[1:0]!=0: state=FAULT, fault=1, fault_addr=redirect_target, out_valid=0, PC unchanged.
  2. redirect=1, aligned: PC=redirect_target, out_valid=0 (flush the buffered instruction, even if out_ready=1 this cycle). The next-state check for DONE applies to the new PC next cycle.
  3. !in_range: state=DONE, done=1, PC held. A valid buffer still drains: out_valid clears when out_ready=1.
  4. accept=1: out_instr=Instruction, out_pc=PC, out_valid=1, PC=PC+4.
  5. accept=0 (stall): PC, out_instr, out_pc and out_valid held stable.
- Latency: an instruction appears on out_* the cycle after its PC is on Inst_Address. With out_ready held at 1, throughput is one instruction per cycle.
- DONE:
  - Aligned redirect: PC=target, done=0, state=FETCH.
  - Misaligned redirect: FAULT, as in FETCH.
  - Otherwise the buffer only drains.
- FAULT:
  - Inputs ignored, out_valid=0, Inst_Address holds the last PC.
  - Only reset exits.
- Handshake rules:
  - out_* must not change while out_valid=1 && out_ready=0, unless redirect or reset occurs.
  - out_ready is ignored while out_valid=0.
- Inst_Address is always 4-byte aligned, because PC only ever takes RESET_PC, PC+4, or an aligned target.

Decomposition:
- Shared package holds:
  - state encoding constants FETCH=2'd0, DONE=2'd1, FAULT=2'd2;
  - XLEN=64 and ILEN=32;
  - RESET_PC default.
- One natural sub-module: ifid_buffer, the single-entry valid/ready register with load, hold and flush. The PC and state logic stay in the top.
- The top-level bench instantiates the existing instruction memory alongside this block.

Test Plan:
1. Memory preloaded with words 0x02853483, 0x009A84B3, 0x00148493, 0x02953423; reset for 2 cycles, then out_ready=1 -> over 4 consecutive cycles out_pc=0,4,8,12 with those words in order. The next cycle done=1 and out_valid=0.
2. out_ready=0 for 3 cycles while out_pc=4 -> out_instr stays 0x009A84B3, Inst_Address stays 8. Releasing out_ready gives out_pc=8 on the next cycle.
3. redirect=1, target=0 while out_pc=8 is valid and out_ready=1 -> next cycle out_valid=0, Inst_Address=0. The cycle after that, out_pc=0 with 0x02853483.
4. In DONE, redirect to 8 -> done=0; next cycles out_pc=8, then 12, then done=1 again.
5. redirect target=6 -> fault=1, fault_addr=6, out_valid=0. Further redirects are ignored; reset clears fault and restarts at PC 0.
6. Assert reset during a stall with out_valid=1 -> the next cycle out_valid=0, Inst_Address=0, done=0, fault=0.
